// File: rtl/dmem_pkg.sv
// Shared types and constants for the wait-stated data memory controller.
package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10
   } mem_size_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } dmem_state_t;

   localparam int WAIT_W = 4;

endpackage

// File: rtl/dmem_align.sv
// Lane steering for byte/halfword/word accesses: byte enables, write-data
// replication, read-data extraction and misalignment detection.
module dmem_align
   import dmem_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rword,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_rdata,
   output logic        o_misaligned
);

   logic [31:0] w_rshift;

   // Offsets are always aligned down; the caller decides what a misaligned access means.
   always_comb begin
      o_be         = 4'b1111;
      o_wdata      = i_wdata;
      o_rdata      = i_rword;
      o_misaligned = 1'b0;
      w_rshift     = i_rword >> {i_addr_lo, 3'b000};
      case (i_size)
         SZ_BYTE: begin
            o_be    = 4'b0001 << i_addr_lo;
            o_wdata = {4{i_wdata[7:0]}};
            o_rdata = {24'h000000, w_rshift[7:0]};
         end
         SZ_HALF: begin
            o_be         = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            o_wdata      = {2{i_wdata[15:0]}};
            o_rdata      = {16'h0000, (i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0])};
            o_misaligned = i_addr_lo[0];
         end
         default: begin
            o_misaligned = |i_addr_lo;
         end
      endcase
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Wait-stated data memory with req/ready handshake and byte/half/word sizes.
// Define DMEM_ERR_EN to suppress misaligned accesses and flag them on o_err.
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int WAIT  = 2
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req,
   input  logic        i_we,
   input  logic [1:0]  i_size,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   output logic        o_ready,
   output logic        o_busy,
   output logic        o_err
);

   localparam int AW = $clog2(DEPTH);

   dmem_state_t       r_state;
   logic [WAIT_W-1:0] r_cnt;
   logic              r_we;
   logic [1:0]        r_size;
   logic [AW+1:0]     r_addr;
   logic [31:0]       r_wdata;
   logic [31:0]       r_rdata;
   logic              r_ready;
   logic              r_busy;
   logic [31:0]       r_mem [DEPTH];

   logic [AW-1:0]     w_idx;
   logic [31:0]       w_rword;
   logic [3:0]        w_be;
   logic [31:0]       w_wdata_sh;
   logic [31:0]       w_rdata_ext;
   logic              w_mis;
   logic              w_fault;
   logic              w_access;
   logic              w_accept;

   assign w_idx    = r_addr[AW+1:2];
   assign w_rword  = r_mem[w_idx];
   assign w_access = (r_state == BUSY) && (r_cnt == '0);
   assign w_accept = i_req && ((r_state == IDLE) || (r_state == DONE));

   dmem_align u_align (
      .i_size       (r_size),
      .i_addr_lo    (r_addr[1:0]),
      .i_wdata      (r_wdata),
      .i_rword      (w_rword),
      .o_be         (w_be),
      .o_wdata      (w_wdata_sh),
      .o_rdata      (w_rdata_ext),
      .o_misaligned (w_mis)
   );

`ifdef DMEM_ERR_EN
   logic r_err;
   assign w_fault = w_mis;
   assign o_err   = r_err;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)
         r_err <= 1'b0;
      else
         r_err <= w_access && w_mis;
   end
`else
   assign w_fault = 1'b0 & w_mis;
   assign o_err   = 1'b0;
`endif

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_we    <= 1'b0;
         r_size  <= 2'b00;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_ready <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_ready <= 1'b0;
         case (r_state)
            IDLE, DONE: begin
               if (w_accept) begin
                  r_we    <= i_we;
                  r_size  <= i_size;
                  r_addr  <= i_addr[AW+1:0];
                  r_wdata <= i_wdata;
                  r_cnt   <= WAIT_W'(WAIT);
                  r_busy  <= 1'b1;
                  r_state <= BUSY;
               end else begin
                  r_state <= IDLE;
               end
            end
            BUSY: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 1'b1;
               end else begin
                  if (!r_we)
                     r_rdata <= w_fault ? 32'h0 : w_rdata_ext;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= DONE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Array is deliberately not reset; reset only abandons the pending access.
   always_ff @(posedge i_clk) begin
      if (w_access && r_we && !w_fault && !i_reset) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i])
               r_mem[w_idx][8*i +: 8] <= w_wdata_sh[8*i +: 8];
         end
      end
   end

   assign o_rdata = r_rdata;
   assign o_ready = r_ready;
   assign o_busy  = r_busy;

endmodule
